// File: rtl/is_out_collector_if.sv
// Handshake and control bundle of the output collector: MAC results in, packed words out.
interface is_out_collector_if #(
  parameter int unsigned CNT_W = 16
);
  logic             OC_clk_is_enable;
  logic             OC_in_en;
  logic             OC_in_last;
  logic [31:0]      OC_in_data;
  logic [4:0]       OC_shift;
  logic             OC_relu_en;
  logic             OC_flush;
  logic             OC_clear;
  logic [31:0]      OC_out_data;
  logic             OC_out_valid;
  logic             OC_out_ready;
  logic             OC_fifo_full;
  logic             OC_overflow;
  logic             OC_flush_done;
  logic [CNT_W-1:0] OC_word_cnt;

  modport master (
    output OC_clk_is_enable, OC_in_en, OC_in_last, OC_in_data, OC_shift, OC_relu_en,
           OC_flush, OC_clear, OC_out_ready,
    input  OC_out_data, OC_out_valid, OC_fifo_full, OC_overflow, OC_flush_done, OC_word_cnt
  );

  modport slave (
    input  OC_clk_is_enable, OC_in_en, OC_in_last, OC_in_data, OC_shift, OC_relu_en,
           OC_flush, OC_clear, OC_out_ready,
    output OC_out_data, OC_out_valid, OC_fifo_full, OC_overflow, OC_flush_done, OC_word_cnt
  );
endinterface

// File: rtl/is_out_collector.sv
// Output stage after the last MAC: requantizes final sums to int8, packs four per word,
// and buffers the words in a FIFO for the output DMA.
module is_out_collector #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input logic               OC_CLK,
  input logic               OC_RSTN,
  is_out_collector_if.slave oc
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic              s1_vld_q, s1_vld_d;
  logic [7:0]        s1_byte_q, s1_byte_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [23:0]       pack_q, pack_d;
  logic              push_vld_q, push_vld_d;
  logic              push_flush_q, push_flush_d;
  logic [31:0]       push_word_q, push_word_d;
  logic              flush_pend_q, flush_pend_d;
  logic              flush_done_q, flush_done_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [31:0]       mem [FIFO_DEPTH];

  logic               en, final_in, empty, full, pop, push_ok, flush_exec, mem_we;
  logic [32:0]        rnd;
  logic signed [32:0] sum, shd;
  logic [7:0]         qbyte;

  assign en         = oc.OC_clk_is_enable;
  assign final_in   = oc.OC_in_en && oc.OC_in_last;
  assign empty      = (wr_q == rd_q);
  assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop        = en && !empty && oc.OC_out_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok    = push_vld_q && (!full || pop);
  assign flush_exec = flush_pend_q && !s1_vld_q && !final_in;
  assign mem_we     = en && !oc.OC_clear && push_ok;

  // Round-half-up, arithmetic shift, optional ReLU, saturate; 33 bits so rounding never wraps.
  always_comb begin
    rnd = '0;
    if (oc.OC_shift != 5'd0) rnd = 33'd1 << (oc.OC_shift - 5'd1);
    sum = $signed({oc.OC_in_data[31], oc.OC_in_data}) + $signed(rnd);
    shd = sum >>> oc.OC_shift;
    if (oc.OC_relu_en && shd[32]) qbyte = 8'h00;
    else if (shd > 33'sd127)      qbyte = 8'h7f;
    else if (shd < -33'sd128)     qbyte = 8'h80;
    else                          qbyte = shd[7:0];
  end

  always_comb begin
    s1_vld_d     = s1_vld_q;
    s1_byte_d    = s1_byte_q;
    ptr_d        = ptr_q;
    pack_d       = pack_q;
    push_vld_d   = 1'b0;
    push_flush_d = 1'b0;
    push_word_d  = push_word_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;
    overflow_d   = overflow_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    if (oc.OC_clear) begin
      s1_vld_d     = 1'b0;
      s1_byte_d    = '0;
      ptr_d        = '0;
      pack_d       = '0;
      push_word_d  = '0;
      flush_pend_d = 1'b0;
      overflow_d   = 1'b0;
      cnt_d        = '0;
      wr_d         = '0;
      rd_d         = '0;
    end else begin
      s1_vld_d = final_in;
      if (final_in) s1_byte_d = qbyte;

      if (s1_vld_q) begin
        unique case (ptr_q)
          2'd0: pack_d[7:0]   = s1_byte_q;
          2'd1: pack_d[15:8]  = s1_byte_q;
          2'd2: pack_d[23:16] = s1_byte_q;
          2'd3: begin
            push_vld_d  = 1'b1;
            push_word_d = {s1_byte_q, pack_q};
            pack_d      = '0;
          end
        endcase
        ptr_d = ptr_q + 2'd1;
      end else if (flush_exec) begin
        if (ptr_q != 2'd0) begin
          // Unwritten lanes are already zero because pack_q is cleared per word.
          push_vld_d   = 1'b1;
          push_flush_d = 1'b1;
          push_word_d  = {8'h00, pack_q};
          pack_d       = '0;
          ptr_d        = '0;
        end else begin
          flush_done_d = 1'b1;
        end
      end

      flush_pend_d = flush_exec ? 1'b0 : (flush_pend_q || oc.OC_flush);

      if (push_vld_q) begin
        if (push_ok) begin
          wr_d  = wr_q + 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          overflow_d = 1'b1;
        end
        if (push_flush_q) flush_done_d = 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge OC_CLK or negedge OC_RSTN) begin
    if (!OC_RSTN) begin
      s1_vld_q     <= 1'b0;
      s1_byte_q    <= '0;
      ptr_q        <= '0;
      pack_q       <= '0;
      push_vld_q   <= 1'b0;
      push_flush_q <= 1'b0;
      push_word_q  <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      cnt_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
    end else if (en) begin
      s1_vld_q     <= s1_vld_d;
      s1_byte_q    <= s1_byte_d;
      ptr_q        <= ptr_d;
      pack_q       <= pack_d;
      push_vld_q   <= push_vld_d;
      push_flush_q <= push_flush_d;
      push_word_q  <= push_word_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      overflow_q   <= overflow_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
    end
  end

  always_ff @(posedge OC_CLK) begin
    if (mem_we) mem[wr_q[AW-1:0]] <= push_word_q;
  end

  assign oc.OC_out_data   = empty ? 32'h0 : mem[rd_q[AW-1:0]];
  assign oc.OC_out_valid  = !empty;
  assign oc.OC_fifo_full  = full;
  assign oc.OC_overflow   = overflow_q;
  assign oc.OC_flush_done = flush_done_q;
  assign oc.OC_word_cnt   = cnt_q;
endmodule

// File: tb/tb_is_out_collector.sv
// Bench for is_out_collector: quantizer vector table, hand-written corner sequences,
// and a randomized run against a byte/word queue model.
module tb_is_out_collector;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  is_out_collector_if #(.CNT_W(16)) ocif ();

  is_out_collector #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .OC_CLK  (clk),
    .OC_RSTN (rstn),
    .oc      (ocif.slave)
  );

  int n_chk = 0;
  int n_pass = 0;
  int fd_cnt = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shift;
    logic        relu;
    logic [7:0]  exp_byte;
  } qvec_t;

  logic [7:0]  acc [$];
  logic [31:0] exp_q [$];
  int          n_words;
  int          n_done;

  always @(negedge clk) begin
    if (ocif.OC_flush_done && ocif.OC_clk_is_enable) fd_cnt <= fd_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] d, input int sh, input bit relu);
    longint v;
    v = longint'($signed(d));
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [31:0] mk_word(input int w);
    return {8'(w * 4 + 3), 8'(w * 4 + 2), 8'(w * 4 + 1), 8'(w * 4)};
  endfunction

  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic relu);
    ocif.OC_in_en = 1'b1;
    ocif.OC_in_last = 1'b1;
    ocif.OC_in_data = d;
    ocif.OC_shift = sh;
    ocif.OC_relu_en = relu;
    tick();
    ocif.OC_in_en = 1'b0;
    ocif.OC_in_last = 1'b0;
  endtask

  task automatic send_word(input int w);
    for (int j = 0; j < 4; j++) send(32'(w * 4 + j), 5'd0, 1'b0);
  endtask

  task automatic pulse_flush();
    ocif.OC_flush = 1'b1;
    tick();
    ocif.OC_flush = 1'b0;
  endtask

  task automatic pulse_clear();
    ocif.OC_clear = 1'b1;
    tick();
    ocif.OC_clear = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    int k;
    k = 0;
    while (!ocif.OC_out_valid && k < 20) begin
      tick();
      k++;
    end
    chk(name, ocif.OC_out_data, exp);
    ocif.OC_out_ready = 1'b1;
    tick();
    ocif.OC_out_ready = 1'b0;
  endtask

  task automatic rcycle(input bit e, input bit ie, input bit fl);
    logic [31:0] w;
    ocif.OC_clk_is_enable = e;
    ocif.OC_in_en = ie;
    ocif.OC_in_last = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 2))
      0: ocif.OC_in_data = 32'($urandom_range(0, 800)) - 32'd400;
      1: ocif.OC_in_data = $urandom;
      default: ocif.OC_in_data = $urandom_range(0, 1) ? 32'h7fffffff - $urandom_range(0, 255)
                                                       : 32'h80000000 + $urandom_range(0, 255);
    endcase
    ocif.OC_shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                : 5'($urandom_range(0, 8));
    ocif.OC_relu_en = $urandom_range(0, 1);
    ocif.OC_flush = fl;
    ocif.OC_out_ready = ($urandom_range(0, 3) != 0);
    if (e && ocif.OC_out_valid && ocif.OC_out_ready) begin
      if (exp_q.size() == 0) chk("rand_unexpected_word", ocif.OC_out_data, 32'hdeadbeef);
      else chk("rand_pop", ocif.OC_out_data, exp_q.pop_front());
    end
    if (e && ie && ocif.OC_in_last) begin
      acc.push_back(ref_byte(ocif.OC_in_data, int'(ocif.OC_shift), ocif.OC_relu_en));
      if (acc.size() == 4) begin
        exp_q.push_back({acc[3], acc[2], acc[1], acc[0]});
        n_words++;
        acc.delete();
      end
    end
    if (e && fl) begin
      n_done++;
      if (acc.size() > 0) begin
        w = '0;
        for (int k = 0; k < acc.size(); k++) w[k*8 +: 8] = acc[k];
        exp_q.push_back(w);
        n_words++;
        acc.delete();
      end
    end
    tick();
  endtask

  task automatic rflush();
    rcycle(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) rcycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    qvec_t vecs [$];
    int    base;
    int    cnt0;
    logic [31:0] d0;

    vecs = '{
      '{32'd100,       5'd0,  1'b0, 8'h64},
      '{-32'sd5,       5'd0,  1'b0, 8'hfb},
      '{32'd300,       5'd0,  1'b0, 8'h7f},
      '{-32'sd300,     5'd0,  1'b0, 8'h80},
      '{32'h17,        5'd4,  1'b0, 8'h01},
      '{32'h18,        5'd4,  1'b0, 8'h02},
      '{-32'sd9,       5'd1,  1'b0, 8'hfc},
      '{-32'sd9,       5'd1,  1'b1, 8'h00},
      '{32'h7fffffff,  5'd31, 1'b0, 8'h01},
      '{32'h80000000,  5'd31, 1'b0, 8'hff},
      '{32'd255,       5'd1,  1'b0, 8'h7f},
      '{-32'sd257,     5'd1,  1'b0, 8'h80},
      '{-32'sd128,     5'd0,  1'b0, 8'h80},
      '{32'd127,       5'd0,  1'b1, 8'h7f}
    };

    ocif.OC_clk_is_enable = 1'b1;
    ocif.OC_in_en = 1'b0;
    ocif.OC_in_last = 1'b0;
    ocif.OC_in_data = '0;
    ocif.OC_shift = '0;
    ocif.OC_relu_en = 1'b0;
    ocif.OC_flush = 1'b0;
    ocif.OC_clear = 1'b0;
    ocif.OC_out_ready = 1'b0;
    #23;
    chk("reset_valid", 32'(ocif.OC_out_valid), 32'd0);
    chk("reset_data", ocif.OC_out_data, 32'd0);
    chk("reset_cnt", 32'(ocif.OC_word_cnt), 32'd0);
    chk("reset_flags", {29'd0, ocif.OC_fifo_full, ocif.OC_overflow, ocif.OC_flush_done}, 32'd0);
    rstn = 1'b1;
    tick();

    // Four sums, cycle-exact latency to out_valid.
    send(32'd100, 5'd0, 1'b0);
    send(-32'sd5, 5'd0, 1'b0);
    send(32'd300, 5'd0, 1'b0);
    send(-32'sd300, 5'd0, 1'b0);
    chk("lat_e0", 32'(ocif.OC_out_valid), 32'd0);
    tick();
    chk("lat_e1", 32'(ocif.OC_out_valid), 32'd0);
    tick();
    chk("lat_e2", 32'(ocif.OC_out_valid), 32'd1);
    chk("word4_data", ocif.OC_out_data, 32'h807ffb64);
    chk("word4_cnt", 32'(ocif.OC_word_cnt), 32'd1);
    pop_check("word4_pop", 32'h807ffb64);
    chk("word4_empty", 32'(ocif.OC_out_valid), 32'd0);

    // Quantizer table, one byte per flushed word.
    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].shift, vecs[i].relu);
      pulse_flush();
      pop_check($sformatf("quant_%0d", i), {24'h0, vecs[i].exp_byte});
    end

    // Partials interleaved among finals are ignored.
    for (int j = 0; j < 4; j++) begin
      ocif.OC_in_en = 1'b1;
      ocif.OC_in_last = 1'b0;
      ocif.OC_in_data = 32'd77;
      tick();
      send(32'(j + 40), 5'd0, 1'b0);
    end
    pop_check("partials", 32'h2b2a2928);

    // Flush with two bytes, then flush with empty packer.
    base = fd_cnt;
    send(32'd1, 5'd0, 1'b0);
    send(32'd2, 5'd0, 1'b0);
    pulse_flush();
    pop_check("flush_word", 32'h00000201);
    repeat (3) tick();
    chk("flush_done_once", 32'(fd_cnt - base), 32'd1);
    base = fd_cnt;
    cnt0 = int'(ocif.OC_word_cnt);
    pulse_flush();
    repeat (4) tick();
    chk("flush0_done", 32'(fd_cnt - base), 32'd1);
    chk("flush0_novalid", 32'(ocif.OC_out_valid), 32'd0);
    chk("flush0_cnt", 32'(ocif.OC_word_cnt), 32'(cnt0));

    // Overflow: nine words into an eight-deep FIFO with ready low.
    pulse_clear();
    for (int w = 0; w < 9; w++) send_word(w);
    repeat (3) tick();
    chk("ovf_full", 32'(ocif.OC_fifo_full), 32'd1);
    chk("ovf_flag", 32'(ocif.OC_overflow), 32'd1);
    chk("ovf_cnt", 32'(ocif.OC_word_cnt), 32'd8);
    for (int w = 0; w < 8; w++) pop_check($sformatf("ovf_drain_%0d", w), mk_word(w));
    chk("ovf_drained", 32'(ocif.OC_out_valid), 32'd0);
    pulse_clear();
    chk("clr_valid", 32'(ocif.OC_out_valid), 32'd0);
    chk("clr_ovf", 32'(ocif.OC_overflow), 32'd0);
    chk("clr_cnt", 32'(ocif.OC_word_cnt), 32'd0);

    // Push and pop on the same edge with the FIFO full.
    for (int w = 0; w < 9; w++) send_word(w);
    tick();
    ocif.OC_out_ready = 1'b1;
    tick();
    ocif.OC_out_ready = 1'b0;
    chk("pp_noovf", 32'(ocif.OC_overflow), 32'd0);
    chk("pp_full", 32'(ocif.OC_fifo_full), 32'd1);
    chk("pp_cnt", 32'(ocif.OC_word_cnt), 32'd9);
    for (int w = 1; w < 9; w++) pop_check($sformatf("pp_drain_%0d", w), mk_word(w));

    // Clock enable held low mid-fill.
    pulse_clear();
    for (int j = 0; j < 4; j++) send(32'(10 + j), 5'd0, 1'b0);
    send(32'd20, 5'd0, 1'b0);
    send(32'd21, 5'd0, 1'b0);
    ocif.OC_clk_is_enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ocif.OC_in_en = k[0];
      ocif.OC_in_last = 1'b1;
      ocif.OC_in_data = $urandom;
      ocif.OC_out_ready = ~k[0];
      tick();
    end
    chk("gate_valid", 32'(ocif.OC_out_valid), 32'd1);
    chk("gate_data", ocif.OC_out_data, 32'h0d0c0b0a);
    chk("gate_cnt", 32'(ocif.OC_word_cnt), 32'd1);
    ocif.OC_clk_is_enable = 1'b1;
    ocif.OC_in_en = 1'b0;
    ocif.OC_out_ready = 1'b0;
    send(32'd22, 5'd0, 1'b0);
    send(32'd23, 5'd0, 1'b0);
    repeat (3) tick();
    pop_check("gate_word_a", 32'h0d0c0b0a);
    pop_check("gate_word_b", 32'h17161514);
    chk("gate_cnt2", 32'(ocif.OC_word_cnt), 32'd2);

    // Asynchronous reset mid-fill.
    send_word(3);
    send(32'd5, 5'd0, 1'b0);
    repeat (3) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(ocif.OC_out_valid), 32'd0);
    chk("arst_data", ocif.OC_out_data, 32'd0);
    chk("arst_cnt", 32'(ocif.OC_word_cnt), 32'd0);
    chk("arst_flags", {29'd0, ocif.OC_fifo_full, ocif.OC_overflow, ocif.OC_flush_done}, 32'd0);
    #3;
    rstn = 1'b1;
    tick();
    for (int j = 1; j < 5; j++) send(32'(j), 5'd0, 1'b0);
    pop_check("arst_fresh_word", 32'h04030201);
    chk("arst_cnt2", 32'(ocif.OC_word_cnt), 32'd1);

    // Randomized run against the queue model.
    pulse_clear();
    n_words = 0;
    n_done = 0;
    base = fd_cnt;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) rflush();
      else rcycle($urandom_range(0, 9) != 0, $urandom_range(0, 1), 1'b0);
    end
    rflush();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || ocif.OC_out_valid); i++) begin
      ocif.OC_clk_is_enable = 1'b1;
      ocif.OC_in_en = 1'b0;
      ocif.OC_out_ready = 1'b1;
      if (ocif.OC_out_valid) begin
        if (exp_q.size() == 0) chk("rand_extra_word", ocif.OC_out_data, 32'hdeadbeef);
        else chk("rand_drain", ocif.OC_out_data, exp_q.pop_front());
      end
      tick();
    end
    ocif.OC_out_ready = 1'b0;
    tick();
    chk("rand_model_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_dut_empty", 32'(ocif.OC_out_valid), 32'd0);
    chk("rand_cnt", 32'(ocif.OC_word_cnt), 32'(n_words[15:0]));
    chk("rand_no_ovf", 32'(ocif.OC_overflow), 32'd0);
    d0 = 32'(fd_cnt - base);
    chk("rand_flush_done", d0, 32'(n_done));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
